// File: rtl/vive_lfsr_pkg.sv
// Shared constants and types for the lighthouse sweep LFSR and its offset finder.
// Polynomials are 17-bit tap masks; the all-zero state is never part of a sequence.
package vive_lfsr_pkg;

   localparam int unsigned LFSR_WIDTH      = 17;
   localparam int unsigned LFSR_ARM_CYCLES = 2;

   localparam logic [LFSR_WIDTH-1:0] POLY_LH_0 = 17'h1D258;
   localparam logic [LFSR_WIDTH-1:0] POLY_LH_1 = 17'h17E04;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StSearch,
      StResp
   } finder_state_e;

endpackage

// File: rtl/lfsr_offset_finder.sv
// Drives a sibling lfsr and watches its value/iteration stream until the value equals the
// requested word, then reports the iteration number as that word's offset in the sequence.
module lfsr_offset_finder
   import vive_lfsr_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] START_DATA = 17'h00001,
   parameter int unsigned           MAX_ITER   = 131071
) (
   input  logic                  clk_96MHz,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [LFSR_WIDTH-1:0] req_target,
   input  logic [LFSR_WIDTH-1:0] req_polynomial,
   output logic                  lfsr_enable,
   output logic [LFSR_WIDTH-1:0] lfsr_polynomial,
   output logic [LFSR_WIDTH-1:0] lfsr_start_data,
   input  logic [LFSR_WIDTH-1:0] lfsr_value,
   input  logic [LFSR_WIDTH-1:0] lfsr_iteration,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [LFSR_WIDTH-1:0] res_offset,
   output logic                  res_found
);

   localparam logic [LFSR_WIDTH-1:0] MAX_ITER_W = LFSR_WIDTH'(MAX_ITER);
   localparam logic [1:0]            ARM_LAST   = 2'(LFSR_ARM_CYCLES - 1);

   finder_state_e         state_q, state_d;
   logic [1:0]            arm_cnt_q, arm_cnt_d;
   logic [LFSR_WIDTH-1:0] target_q, target_d;
   logic [LFSR_WIDTH-1:0] poly_q, poly_d;
   logic                  ready_q, ready_d;
   logic                  enable_q, enable_d;
   logic                  valid_q, valid_d;
   logic [LFSR_WIDTH-1:0] offset_q, offset_d;
   logic                  found_q, found_d;

   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      target_d  = target_q;
      poly_d    = poly_q;
      ready_d   = ready_q;
      enable_d  = enable_q;
      valid_d   = valid_q;
      offset_d  = offset_q;
      found_d   = found_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid && ready_q) begin
               target_d = req_target;
               poly_d   = req_polynomial;
               ready_d  = 1'b0;
               if (req_target == '0) begin
                  // Zero is unreachable: answer without ever starting the lfsr.
                  offset_d = '0;
                  found_d  = 1'b0;
                  state_d  = StResp;
               end else begin
                  enable_d  = 1'b1;
                  arm_cnt_d = '0;
                  state_d   = StArm;
               end
            end
         end

         StArm: begin
            // Skip compares while the lfsr walks IDLE->LOAD and still shows the last search.
            if (arm_cnt_q == ARM_LAST) begin
               state_d = StSearch;
            end else begin
               arm_cnt_d = arm_cnt_q + 2'd1;
            end
         end

         StSearch: begin
            if (lfsr_value == target_q) begin
               offset_d = lfsr_iteration;
               found_d  = 1'b1;
               enable_d = 1'b0;
               valid_d  = 1'b1;
               state_d  = StResp;
            end else if (lfsr_iteration == MAX_ITER_W) begin
               offset_d = '0;
               found_d  = 1'b0;
               enable_d = 1'b0;
               valid_d  = 1'b1;
               state_d  = StResp;
            end
         end

         StResp: begin
            // Zero-target path enters with valid low and raises it one cycle later.
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (res_ready) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = StIdle;
            end
         end

         default: begin
            state_d  = StIdle;
            ready_d  = 1'b1;
            enable_d = 1'b0;
            valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_96MHz or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         arm_cnt_q <= '0;
         target_q  <= '0;
         poly_q    <= '0;
         ready_q   <= 1'b1;
         enable_q  <= 1'b0;
         valid_q   <= 1'b0;
         offset_q  <= '0;
         found_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         target_q  <= target_d;
         poly_q    <= poly_d;
         ready_q   <= ready_d;
         enable_q  <= enable_d;
         valid_q   <= valid_d;
         offset_q  <= offset_d;
         found_q   <= found_d;
      end
   end

   assign req_ready       = ready_q;
   assign lfsr_enable     = enable_q;
   assign lfsr_polynomial = poly_q;
   assign lfsr_start_data = START_DATA;
   assign res_valid       = valid_q;
   assign res_offset      = offset_q;
   assign res_found       = found_q;

endmodule
